// File: rtl/red_pitaya_asg_pkg.sv
// Shared definitions for the ASG streaming loader: sample/counter widths and loader FSM encoding.
package red_pitaya_asg_pkg;

  localparam int unsigned SMP_W      = 14;
  localparam int unsigned URUN_CNT_W = 16;
  localparam int unsigned BLK_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FILL  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/red_pitaya_asg_stream_fifo.sv
// Synchronous sample FIFO with registered full/empty flags and a synchronous flush.
module red_pitaya_asg_stream_fifo
  import red_pitaya_asg_pkg::*;
#(
  parameter int unsigned FDW = 4
) (
  input  logic             dac_clk_i,
  input  logic             dac_rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [SMP_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [SMP_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 2 ** FDW;
  localparam logic [FDW:0] FULL_CNT = {1'b1, {FDW{1'b0}}};

  logic [SMP_W-1:0] mem [DEPTH];
  logic [FDW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FDW:0]     cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q & ~flush_i;
  assign do_pop  = pop_i & ~empty_q & ~flush_i;
  assign rdata_o = mem[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge dac_clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/red_pitaya_asg_stream_fill.sv
// Streams samples into the ASG waveform RAM: primes the whole RAM, then refills whichever half the reader has left.
module red_pitaya_asg_stream_fill
  import red_pitaya_asg_pkg::*;
#(
  parameter int unsigned RSZ = 14,
  parameter int unsigned FDW = 4
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rstn_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [SMP_W-1:0]      s_dat_i,
  input  logic                  s_vld_i,
  output logic                  s_rdy_o,
  input  logic [RSZ-1:0]        buf_rpnt_i,
  output logic                  buf_we_o,
  output logic [RSZ-1:0]        buf_addr_o,
  output logic [SMP_W-1:0]      buf_wdata_o,
  output logic [1:0]            state_o,
  output logic                  primed_o,
  output logic                  underrun_o,
  output logic [URUN_CNT_W-1:0] urun_cnt_o,
  output logic [BLK_CNT_W-1:0]  blk_cnt_o
);

  fill_state_e      state_q, state_d;
  logic [SMP_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             push, pop, active;
  logic [RSZ-1:0]   wr_cnt_q;
  logic             next_half_q, rp_msb_q, in_half_q;
  logic             in_half, urun_edge, prime_last, fill_last;
  logic             unused_rpnt;

  // Ready is held low during reset even if the source already has en_i high.
  assign s_rdy_o     = en_i & ~fifo_full & dac_rstn_i;
  assign push        = s_vld_i & s_rdy_o;
  assign active      = (state_q == ST_PRIME) | (state_q == ST_FILL);
  assign pop         = en_i & active & ~fifo_empty;
  assign prime_last  = pop & (state_q == ST_PRIME) & (&wr_cnt_q);
  assign fill_last   = pop & (state_q == ST_FILL) & (&wr_cnt_q[RSZ-2:0]);
  assign in_half     = (rp_msb_q == next_half_q);
  assign urun_edge   = (state_q == ST_FILL) & in_half & ~in_half_q;
  assign state_o     = state_q;
  assign unused_rpnt = ^buf_rpnt_i[RSZ-2:0];

  red_pitaya_asg_stream_fifo #(.FDW(FDW)) u_fifo (
    .dac_clk_i  (dac_clk_i),
    .dac_rstn_i (dac_rstn_i),
    .flush_i    (~en_i),
    .push_i     (push),
    .wdata_i    (s_dat_i),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (prime_last) state_d = ST_WAIT;
        ST_WAIT:  if (!in_half)   state_d = ST_FILL;
        ST_FILL:  if (fill_last)  state_d = ST_WAIT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q     <= ST_IDLE;
      rp_msb_q    <= 1'b0;
      in_half_q   <= 1'b0;
      wr_cnt_q    <= '0;
      next_half_q <= 1'b0;
      primed_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rp_msb_q  <= buf_rpnt_i[RSZ-1];
      in_half_q <= in_half;
      if (state_q == ST_IDLE) begin
        wr_cnt_q    <= '0;
        next_half_q <= 1'b0;
      end else if (pop) begin
        wr_cnt_q <= (prime_last | fill_last) ? '0 : wr_cnt_q + 1'b1;
        if (prime_last) next_half_q <= 1'b0;
        if (fill_last)  next_half_q <= ~next_half_q;
      end
      if (!en_i || state_q == ST_IDLE) primed_o <= 1'b0;
      else if (prime_last)             primed_o <= 1'b1;
    end
  end

  // Write port is registered: one RAM write per pop, one cycle after it.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      buf_we_o    <= 1'b0;
      buf_addr_o  <= '0;
      buf_wdata_o <= '0;
    end else begin
      buf_we_o <= pop;
      if (pop) begin
        buf_addr_o  <= (state_q == ST_PRIME) ? wr_cnt_q : {next_half_q, wr_cnt_q[RSZ-2:0]};
        buf_wdata_o <= fifo_rdata;
      end
    end
  end

  // Underrun set wins over a coincident clear and restarts the count at one.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      underrun_o <= 1'b0;
      urun_cnt_o <= '0;
      blk_cnt_o  <= '0;
    end else begin
      if (urun_edge) begin
        underrun_o <= 1'b1;
        if (clr_i)             urun_cnt_o <= URUN_CNT_W'(1);
        else if (~&urun_cnt_o) urun_cnt_o <= urun_cnt_o + 1'b1;
      end else if (clr_i) begin
        underrun_o <= 1'b0;
        urun_cnt_o <= '0;
      end
      if (fill_last) blk_cnt_o <= blk_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_stream_fill.sv
// Directed bench for the ASG streaming loader with a small RAM (16 words) and a 4-deep FIFO.
module tb_red_pitaya_asg_stream_fill;

  localparam int RSZ = 4;
  localparam int FDW = 2;

  logic            dac_clk_i = 1'b0;
  logic            dac_rstn_i = 1'b0;
  logic            en_i = 1'b0;
  logic            clr_i = 1'b0;
  logic [13:0]     s_dat_i = '0;
  logic            s_vld_i = 1'b0;
  logic            s_rdy_o;
  logic [RSZ-1:0]  buf_rpnt_i = '0;
  logic            buf_we_o;
  logic [RSZ-1:0]  buf_addr_o;
  logic [13:0]     buf_wdata_o;
  logic [1:0]      state_o;
  logic            primed_o;
  logic            underrun_o;
  logic [15:0]     urun_cnt_o;
  logic [31:0]     blk_cnt_o;

  red_pitaya_asg_stream_fill #(.RSZ(RSZ), .FDW(FDW)) dut (
    .dac_clk_i   (dac_clk_i),
    .dac_rstn_i  (dac_rstn_i),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .s_dat_i     (s_dat_i),
    .s_vld_i     (s_vld_i),
    .s_rdy_o     (s_rdy_o),
    .buf_rpnt_i  (buf_rpnt_i),
    .buf_we_o    (buf_we_o),
    .buf_addr_o  (buf_addr_o),
    .buf_wdata_o (buf_wdata_o),
    .state_o     (state_o),
    .primed_o    (primed_o),
    .underrun_o  (underrun_o),
    .urun_cnt_o  (urun_cnt_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  always #5 dac_clk_i = ~dac_clk_i;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t         wq[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [13:0] next_dat = '0;
  int          last_hs = 0;

  always @(posedge dac_clk_i) cyc <= cyc + 1;

  always @(negedge dac_clk_i)
    if (buf_we_o) wq.push_back('{addr: int'(buf_addr_o), data: int'(buf_wdata_o), cyc: cyc});

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge dac_clk_i);
    #1;
  endtask

  // Offers n consecutive samples from next_dat, each waiting (bounded) for ready.
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      bit got = 0;
      s_vld_i = 1'b1;
      s_dat_i = next_dat;
      for (int b = 0; b < 60 && !got; b++) begin
        @(negedge dac_clk_i);
        if (s_rdy_o) begin
          got = 1;
          last_hs = cyc;
        end
      end
      if (!got) begin
        check("push_timeout", 32'd0, 32'd1);
        s_vld_i = 1'b0;
        return;
      end
      @(posedge dac_clk_i);
      #1;
      next_dat = next_dat + 14'd1;
    end
    s_vld_i = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int b = 0; b < 200; b++) begin
      if (wq.size() >= n) return;
      @(negedge dac_clk_i);
      #1;
    end
    check("write_timeout", wq.size(), n);
  endtask

  task automatic check_writes(input string tag, input int base, input int addr0, input int dat0, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i >= wq.size()) begin
        check({tag, "_missing"}, base + i, wq.size());
        return;
      end
      check({tag, "_addr"}, wq[base+i].addr, addr0 + i);
      check({tag, "_data"}, wq[base+i].data, dat0 + i);
    end
  endtask

  initial begin
    int hs0, acc, seen, base, wr_after;
    bit hit, took;

    // Reset state
    step(3);
    check("rst_rdy", s_rdy_o, 0);
    check("rst_we", buf_we_o, 0);
    check("rst_state", state_o, 0);
    check("rst_primed", primed_o, 0);
    check("rst_urun", underrun_o, 0);
    check("rst_urun_cnt", urun_cnt_o, 0);
    check("rst_blk", blk_cnt_o, 0);
    dac_rstn_i = 1'b1;
    step(2);

    // 1: prime the whole RAM with 0..15
    en_i = 1'b1;
    push_n(1);
    hs0 = last_hs;
    check("prime_primed_low", primed_o, 0);
    check("prime_state", state_o, 1);
    push_n(15);
    wait_writes(16);
    check("prime_latency", wq[0].cyc - hs0, 2);
    check_writes("prime", 0, 0, 0, 16);
    step(1);
    check("prime_primed", primed_o, 1);
    check("prime_wait", state_o, 2);
    check("prime_count", wq.size(), 16);

    // 2: reader moves to upper half -> refill half 0, then back -> refill half 1
    buf_rpnt_i = 4'd8;
    push_n(8);
    wait_writes(24);
    check_writes("fill0", 16, 0, 16, 8);
    step(1);
    check("fill0_blk", blk_cnt_o, 1);
    check("fill0_wait", state_o, 2);
    check("fill0_urun", underrun_o, 0);
    buf_rpnt_i = 4'd0;
    push_n(8);
    wait_writes(32);
    check_writes("fill1", 24, 8, 24, 8);
    step(1);
    check("fill1_blk", blk_cnt_o, 2);

    // 3: FIFO saturates while waiting, then drains without loss
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      s_vld_i = 1'b1;
      s_dat_i = next_dat;
      @(negedge dac_clk_i);
      took = s_rdy_o;
      @(posedge dac_clk_i);
      #1;
      if (took) begin
        acc++;
        next_dat = next_dat + 14'd1;
      end
    end
    s_vld_i = 1'b0;
    check("full_accepts", acc, 4);
    check("full_rdy", s_rdy_o, 0);
    check("full_no_write", wq.size(), 32);
    buf_rpnt_i = 4'd8;
    push_n(4);
    wait_writes(40);
    check_writes("resume", 32, 0, 32, 8);
    step(1);
    check("resume_blk", blk_cnt_o, 3);

    // 4: refill half 1, then stall a half-0 fill and let the reader re-enter it
    buf_rpnt_i = 4'd0;
    push_n(8);
    wait_writes(48);
    check_writes("fill1b", 40, 8, 40, 8);
    step(1);
    check("fill1b_blk", blk_cnt_o, 4);
    buf_rpnt_i = 4'd8;
    step(3);
    check("stall_state", state_o, 3);
    check("stall_no_urun", underrun_o, 0);
    buf_rpnt_i = 4'd3;
    step(3);
    check("urun_flag", underrun_o, 1);
    check("urun_cnt1", urun_cnt_o, 1);
    step(20);
    check("urun_held_cnt", urun_cnt_o, 1);
    check("urun_held_state", state_o, 3);

    // 5: second entry counts, coincident clear restarts at one, lone clear zeroes
    buf_rpnt_i = 4'd8;
    step(3);
    buf_rpnt_i = 4'd3;
    step(3);
    check("urun_cnt2", urun_cnt_o, 2);
    buf_rpnt_i = 4'd8;
    step(3);
    buf_rpnt_i = 4'd3;
    step(1);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr_coinc_flag", underrun_o, 1);
    check("clr_coinc_cnt", urun_cnt_o, 1);
    step(2);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr_flag", underrun_o, 0);
    check("clr_cnt", urun_cnt_o, 0);

    // 6: drop enable mid-fill after three writes
    buf_rpnt_i = 4'd8;
    base = wq.size();
    hit = 0;
    for (int b = 0; b < 100 && !hit; b++) begin
      s_vld_i = 1'b1;
      s_dat_i = next_dat;
      @(negedge dac_clk_i);
      #1;
      took = s_rdy_o;
      seen = wq.size();
      @(posedge dac_clk_i);
      #1;
      if (took) next_dat = next_dat + 14'd1;
      if (seen >= base + 3) hit = 1;
    end
    check("dis_reached", hit, 1);
    en_i = 1'b0;
    s_vld_i = 1'b0;
    check_writes("dis_writes", base, 0, 48, 3);
    step(1);
    check("dis_we", buf_we_o, 0);
    check("dis_state", state_o, 0);
    check("dis_primed", primed_o, 0);
    check("dis_rdy", s_rdy_o, 0);
    check("dis_blk_kept", blk_cnt_o, 4);
    wr_after = wq.size();
    step(4);
    check("dis_no_write", wq.size(), wr_after);

    // Re-enable restarts priming at address 0 with fresh data only
    en_i = 1'b1;
    next_dat = 14'd200;
    push_n(1);
    wait_writes(wr_after + 1);
    if (wq.size() > wr_after) begin
      check("reen_addr", wq[wr_after].addr, 0);
      check("reen_data", wq[wr_after].data, 200);
    end
    check("reen_state", state_o, 1);
    check("reen_primed", primed_o, 0);
    push_n(2);
    wait_writes(wr_after + 3);

    // Asynchronous reset mid-prime clears outputs without a clock edge
    @(posedge dac_clk_i);
    #2;
    dac_rstn_i = 1'b0;
    #1;
    check("arst_rdy", s_rdy_o, 0);
    check("arst_we", buf_we_o, 0);
    check("arst_addr", buf_addr_o, 0);
    check("arst_wdata", buf_wdata_o, 0);
    check("arst_state", state_o, 0);
    check("arst_primed", primed_o, 0);
    check("arst_blk", blk_cnt_o, 0);
    check("arst_urun", underrun_o, 0);
    step(2);
    dac_rstn_i = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
